bus_comparator_n: RTL and testbench

Parametrised N-channel redundant-bus comparator, successor to the single-pair bus comparator. Each of CH_NUM redundant channels pushes words into its own FIFO. When every channel has a word at its head, one word is popped from each FIFO and compared. The block emits one result word with a match flag and a per-channel disagreement mask, and raises a sticky fault if channels drift out of step.

---
 rtl/bus_cmp_pkg.sv | 25 ++
 rtl/bus_cmp_fifo.sv | 61 ++++++
 rtl/bus_comparator_n.sv | 216 +++++++++++++++++++++
 tb/tb_bus_comparator_n.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_cmp_pkg.sv
// Shared types and helpers for the N-channel redundant-bus comparator.
package bus_cmp_pkg;

  // Skew supervision states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } cmp_state_e;

  // Supported channel count range.
  localparam int CH_NUM_MIN = 2;
  localparam int CH_NUM_MAX = 4;

  // Width needed for the skew counter to hold the value TIMEOUT.
  function automatic int skew_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // True when a channel count lies inside the supported range.
  function automatic bit ch_num_in_range(input int ch_num);
    return (ch_num >= CH_NUM_MIN) && (ch_num <= CH_NUM_MAX);
  endfunction

endpackage

// File: rtl/bus_cmp_fifo.sv
// Single-clock FIFO for one comparator channel. Head word is readable
// combinationally one cycle after it is pushed. Pointers carry one extra
// wrap bit so full/empty are distinguished without a counter.
module bus_cmp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  // Full is judged on the pre-pop state, so a push into a full FIFO is refused
  // even if a pop happens in the same cycle.
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign head      = mem_r[rd_ptr_r[AW-1:0]];

  // Read/write pointer update; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/bus_comparator_n.sv
// N-channel redundant-bus comparator. Each channel fills its own FIFO; when
// every FIFO has a head word, all heads pop together and are compared into a
// registered result. A skew supervisor raises a sticky fault if the FIFOs stay
// partially filled for TIMEOUT cycles.
// Optional feature macro BUS_CMP_VOTE_EN: reference word is the bitwise
// majority of the channels (ties take channel 0); otherwise channel 0's word.
module bus_comparator_n
  import bus_cmp_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CH_NUM     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_NUM-1:0]        in_valid,
  input  logic [CH_NUM*DATA_W-1:0] in_data,
  output logic [CH_NUM-1:0]        in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_match,
  output logic [CH_NUM-1:0]        out_mask,
  output logic                     err_timeout,
  output logic [CH_NUM-1:0]        err_mask,
  input  logic                     err_clr
);
  localparam int                 CNT_W     = skew_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(TIMEOUT);

  cmp_state_e        state_r;
  cmp_state_e        state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic              err_timeout_r;
  logic              err_timeout_nxt_s;
  logic [CH_NUM-1:0] err_mask_r;
  logic [CH_NUM-1:0] err_mask_nxt_s;
  logic              ready_en_r;

  logic [DATA_W-1:0] head_s [CH_NUM];
  logic [CH_NUM-1:0] full_s;
  logic [CH_NUM-1:0] empty_s;
  logic              all_head_s;
  logic              any_head_s;
  logic              pop_ok_s;
  logic              flush_s;

  logic [DATA_W-1:0] ref_word_s;
  logic [CH_NUM-1:0] mask_s;
  logic              match_s;

  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_match_r;
  logic [CH_NUM-1:0] out_mask_r;

`ifdef BUS_CMP_VOTE_EN
  // Bitwise majority across the channel words; an exact tie takes channel 0.
  function automatic logic [DATA_W-1:0] vote_word(input logic [DATA_W-1:0] w [CH_NUM]);
    logic [DATA_W-1:0] r;
    int                ones;
    r = '0;
    for (int b = 0; b < DATA_W; b++) begin
      ones = 0;
      for (int k = 0; k < CH_NUM; k++) begin
        ones = ones + int'(w[k][b]);
      end
      if ((ones + ones) > CH_NUM) begin
        r[b] = 1'b1;
      end else if ((ones + ones) == CH_NUM) begin
        r[b] = w[0][b];
      end else begin
        r[b] = 1'b0;
      end
    end
    return r;
  endfunction
`endif

  // Per-channel FIFOs; they pop together and flush together while faulted.
  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    bus_cmp_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_s),
      .push      (in_valid[k] && in_ready[k]),
      .push_data (in_data[k*DATA_W +: DATA_W]),
      .pop       (pop_ok_s),
      .head      (head_s[k]),
      .full      (full_s[k]),
      .empty     (empty_s[k])
    );
  end

  assign all_head_s = &(~empty_s);
  assign any_head_s = |(~empty_s);
  assign pop_ok_s   = all_head_s && (!out_valid_r || out_ready) && (state_r != FAULT);
  assign flush_s    = (state_r == FAULT);
  assign cnt_inc_s  = cnt_r + CNT_ONE;
  // ready_en_r keeps in_ready low until the first edge after reset release.
  assign in_ready   = (ready_en_r && (state_r != FAULT)) ? ~full_s : '0;

  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_match   = out_match_r;
  assign out_mask    = out_mask_r;
  assign err_timeout = err_timeout_r;
  assign err_mask    = err_mask_r;

  // Reference word, disagreement mask and all-equal flag for the current heads.
  always_comb begin
`ifdef BUS_CMP_VOTE_EN
    ref_word_s = vote_word(head_s);
`else
    ref_word_s = head_s[0];
`endif
    match_s = 1'b1;
    mask_s  = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      mask_s[k] = (head_s[k] != ref_word_s);
      match_s   = match_s & (head_s[k] == head_s[0]);
    end
  end

  // Skew supervisor next-state: counts partial-fill cycles, latches the fault.
  always_comb begin
    state_nxt_s       = state_r;
    cnt_nxt_s         = cnt_r;
    err_timeout_nxt_s = err_timeout_r;
    err_mask_nxt_s    = err_mask_r;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = '0;
        if (any_head_s && !all_head_s) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (all_head_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end else if (cnt_inc_s == CNT_LIMIT) begin
          state_nxt_s       = FAULT;
          cnt_nxt_s         = cnt_inc_s;
          err_timeout_nxt_s = 1'b1;
          err_mask_nxt_s    = empty_s;
        end else begin
          state_nxt_s = WAIT;
          cnt_nxt_s   = cnt_inc_s;
        end
      end
      FAULT: begin
        if (err_clr) begin
          state_nxt_s       = IDLE;
          cnt_nxt_s         = '0;
          err_timeout_nxt_s = 1'b0;
          err_mask_nxt_s    = '0;
        end else begin
          state_nxt_s = FAULT;
        end
      end
      default: begin
        state_nxt_s       = IDLE;
        cnt_nxt_s         = '0;
        err_timeout_nxt_s = 1'b0;
        err_mask_nxt_s    = '0;
      end
    endcase
  end

  // Supervisor state, skew counter, fault flags and post-reset ready enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      err_timeout_r <= 1'b0;
      err_mask_r    <= '0;
      ready_en_r    <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      err_timeout_r <= err_timeout_nxt_s;
      err_mask_r    <= err_mask_nxt_s;
      ready_en_r    <= 1'b1;
    end
  end

  // Result register: loads on a pop, holds until the consumer accepts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_match_r <= 1'b0;
      out_mask_r  <= '0;
    end else if (pop_ok_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= ref_word_s;
      out_match_r <= match_s;
      out_mask_r  <= mask_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_bus_comparator_n.sv
// Self-checking bench for bus_comparator_n: a 2-channel instance (main tests)
// and a 3-channel instance (majority case). Expected results are queued when
// stimulus is driven and compared when the DUT presents a result.
module tb_bus_comparator_n;

  typedef struct packed {
    logic [31:0] data;
    logic        match;
    logic [3:0]  mask;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // Two-channel instance
  logic [1:0]  in_valid;
  logic [63:0] in_data;
  logic [1:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_match;
  logic [1:0]  out_mask;
  logic        err_timeout;
  logic [1:0]  err_mask;
  logic        err_clr;
  // Three-channel instance
  logic [2:0]  in_valid_b;
  logic [95:0] in_data_b;
  logic [2:0]  in_ready_b;
  logic        out_valid_b;
  logic        out_ready_b;
  logic [31:0] out_data_b;
  logic        out_match_b;
  logic [2:0]  out_mask_b;
  logic        err_timeout_b;
  logic [2:0]  err_mask_b;
  logic        err_clr_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;

  bus_comparator_n #(.DATA_W(32), .CH_NUM(2), .FIFO_DEPTH(8), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_match(out_match),
    .out_mask(out_mask), .err_timeout(err_timeout), .err_mask(err_mask), .err_clr(err_clr)
  );

  bus_comparator_n #(.DATA_W(32), .CH_NUM(3), .FIFO_DEPTH(4), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .out_match(out_match_b),
    .out_mask(out_mask_b), .err_timeout(err_timeout_b), .err_mask(err_mask_b), .err_clr(err_clr_b)
  );

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for up to three channel words.
  function automatic exp_t model(input logic [31:0] w0, input logic [31:0] w1,
                                 input logic [31:0] w2, input int n);
    logic [31:0] w [3];
    exp_t        e;
    int          ones;
    w[0] = w0; w[1] = w1; w[2] = w2;
    e = '0;
`ifdef BUS_CMP_VOTE_EN
    for (int b = 0; b < 32; b++) begin
      ones = 0;
      for (int k = 0; k < n; k++) ones += int'(w[k][b]);
      if (2 * ones > n)       e.data[b] = 1'b1;
      else if (2 * ones == n) e.data[b] = w[0][b];
      else                    e.data[b] = 1'b0;
    end
`else
    ones = 0;
    e.data = w0;
`endif
    e.match = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (w[k] != w[0]) e.match = 1'b0;
      if (w[k] != e.data) e.mask[k] = 1'b1;
    end
    return e;
  endfunction

  // Scoreboard for the two-channel instance; also checks hold under backpressure.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1) begin
      if (q_a.size() == 0) begin
        check_value("a_spurious_valid", out_valid, 1'b0);
      end else begin
        check_value("a_data", out_data, q_a[0].data);
        check_value("a_match", out_match, q_a[0].match);
        check_value("a_mask", out_mask, q_a[0].mask);
        if (out_ready === 1'b1) void'(q_a.pop_front());
      end
    end
  end

  // Scoreboard for the three-channel instance.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid_b === 1'b1) begin
      if (q_b.size() == 0) begin
        check_value("b_spurious_valid", out_valid_b, 1'b0);
      end else begin
        check_value("b_data", out_data_b, q_b[0].data);
        check_value("b_match", out_match_b, q_b[0].match);
        check_value("b_mask", out_mask_b, q_b[0].mask);
        if (out_ready_b === 1'b1) void'(q_b.pop_front());
      end
    end
  end

  task automatic push_a(input logic [31:0] d0, input logic [31:0] d1);
    in_valid = 2'b11;
    in_data  = {d1, d0};
    q_a.push_back(model(d0, d1, 32'h0, 2));
    @(posedge clk); #1;
    in_valid = 2'b00;
  endtask

  task automatic wait_ready_a(input int budget);
    int n = 0;
    while (in_ready !== 2'b11 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 2'b11) check_value("ready_wait_expired", in_ready, 2'b11);
  endtask

  task automatic wait_drain_a(input int budget);
    int n = 0;
    while (q_a.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_value("a_drain_queue_empty", q_a.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    rst = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1; err_clr = 1'b0;
    in_valid_b = '0; in_data_b = '0; out_ready_b = 1'b1; err_clr_b = 1'b0;
    #1;
    // Reset values
    check_value("rst_in_ready", in_ready, 2'b00);
    check_value("rst_out_valid", out_valid, 1'b0);
    check_value("rst_out_data", out_data, 32'h0);
    check_value("rst_err_timeout", err_timeout, 1'b0);
    check_value("rst_err_mask", err_mask, 2'b00);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_value("post_rst_in_ready", in_ready, 2'b11);
    check_value("post_rst_in_ready_b", in_ready_b, 3'b111);

    // Basic match with latency check
    in_valid = 2'b11; in_data = {32'hDEADBEEF, 32'hDEADBEEF};
    q_a.push_back(model(32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 2));
    @(posedge clk); #1; in_valid = 2'b00;
    check_value("lat_cycle1_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    check_value("lat_cycle2_valid", out_valid, 1'b1);
    check_value("basic_data", out_data, 32'hDEADBEEF);
    check_value("basic_match", out_match, 1'b1);
    check_value("basic_mask", out_mask, 2'b00);
    wait_drain_a(10);

    // Mismatch
    wait_ready_a(10);
    push_a(32'h00000001, 32'h00000003);
    @(posedge clk); #1;
    check_value("mismatch_match", out_match, 1'b0);
    check_value("mismatch_mask", out_mask, 2'b10);
    wait_drain_a(10);

    // Streaming, mixed equal and single-bit-flip words
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      wait_ready_a(10);
      push_a(w, ($urandom_range(0, 1) == 0) ? w : (w ^ (32'h1 << $urandom_range(0, 31))));
    end
    wait_drain_a(20);

    // Majority case on the three-channel instance
    in_valid_b = 3'b111; in_data_b = {32'h0000005A, 32'h000000A5, 32'h000000A5};
    q_b.push_back(model(32'h000000A5, 32'h000000A5, 32'h0000005A, 3));
    @(posedge clk); #1; in_valid_b = 3'b000;
    @(posedge clk); #1;
    check_value("vote_valid", out_valid_b, 1'b1);
    check_value("vote_data", out_data_b, 32'h000000A5);
    check_value("vote_mask", out_mask_b, 3'b100);
    repeat (3) @(posedge clk); #1;
    check_value("b_queue_empty", q_b.size(), 0);

    // err_clr outside FAULT has no effect
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    check_value("clr_idle_in_ready", in_ready, 2'b11);

    // Skew timeout: only channel 0 pushes
    in_valid = 2'b01; in_data = {32'h0, 32'h00001234};
    @(posedge clk); #1; in_valid = 2'b00;
    repeat (4) @(posedge clk); #1;
    check_value("timeout_not_early", err_timeout, 1'b0);
    @(posedge clk); #1;
    check_value("timeout_fired", err_timeout, 1'b1);
    check_value("timeout_err_mask", err_mask, 2'b10);
    check_value("timeout_in_ready", in_ready, 2'b00);
    repeat (3) @(posedge clk); #1;
    check_value("timeout_sticky", err_timeout, 1'b1);
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    check_value("clr_err_timeout", err_timeout, 1'b0);
    check_value("clr_err_mask", err_mask, 2'b00);
    check_value("clr_in_ready", in_ready, 2'b11);
    check_value("clr_no_output", out_valid, 1'b0);

    // Backpressure and full FIFOs
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wait_ready_a(20);
      push_a(32'hC0DE0000 + i, 32'hC0DE0000 + i);
    end
    check_value("bp_in_ready_full", in_ready, 2'b00);
    repeat (10) @(posedge clk); #1;
    check_value("bp_no_timeout", err_timeout, 1'b0);
    check_value("bp_valid_held", out_valid, 1'b1);
    check_value("bp_still_full", in_ready, 2'b00);
    out_ready = 1'b1;
    wait_drain_a(40);

    // Reset mid-stream: one result held, three words in the FIFOs
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_ready_a(10);
      push_a(32'h5EED0000 + i, 32'h5EED0000 + i);
    end
    #2;
    rst = 1'b0;
    #1;
    check_value("mid_rst_out_valid", out_valid, 1'b0);
    check_value("mid_rst_out_data", out_data, 32'h0);
    check_value("mid_rst_out_match", out_match, 1'b0);
    check_value("mid_rst_out_mask", out_mask, 2'b00);
    check_value("mid_rst_in_ready", in_ready, 2'b00);
    q_a.delete();
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk); #1;
    check_value("after_rst_no_result", out_valid, 1'b0);
    check_value("after_rst_in_ready", in_ready, 2'b11);
    check_value("after_rst_queue", q_a.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
